sub3_bcd2bin: RTL and testbench
===============================

SUB3_BCD2BIN -- requirements
Module: sub3_bcd2bin

Interface
REQ-001 Parameter NDIG, default 3: number of packed BCD input digits.
REQ-002 Parameter BW, default 10: binary output width; SHALL satisfy 2^BW >= 10^NDIG.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 START  input  1  request to convert BCD_IN; sampled each rising edge.
REQ-006 BCD_IN  input  4*NDIG  packed BCD, digit 0 in bits [3:0]; sampled only on the accepting edge.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  one-cycle pulse marking conversion (or rejection) complete.
REQ-009 BIN_OUT  output  BW  registered binary result.
REQ-010 ERR  output  1  high when the last accepted request held a non-BCD digit.

Function
REQ-011 The block SHALL perform reverse double-dabble (shift right, subtract-3 correction), the inverse of the add-3 binary-to-BCD cell.
REQ-012 States SHALL be IDLE and SHIFT; IDLE on reset.
REQ-013 START=1 in IDLE SHALL be accepted; START in SHIFT SHALL be ignored with no effect.
REQ-014 On acceptance with all digits <= 9: load BCD_IN into the digit register, clear the BW-bit shift register and the iteration counter, clear ERR, enter SHIFT, BUSY=1 from the next cycle.
REQ-015 On acceptance with any digit > 9: stay IDLE, ERR=1, DONE=1 for the next cycle only, BIN_OUT unchanged, BUSY stays 0.
REQ-016 Each SHIFT edge SHALL shift {digits, shift register} right by 1 bit, then subtract 3 from every digit whose post-shift value is >= 8, all in the same cycle.
REQ-017 The iteration counter SHALL be wide enough to count to BW and SHALL increment once per SHIFT edge.
REQ-018 The edge performing iteration BW SHALL load the final shift-register value into BIN_OUT, set DONE=1, set BUSY=0, and return to IDLE.
REQ-019 Latency: DONE is high in the cycle after the BW-th rising edge following the accepting edge (BW+1 cycles from the START sample); for defaults, 11 cycles.
REQ-020 DONE SHALL be high for exactly one cycle per accepted request.
REQ-021 BIN_OUT and ERR SHALL hold their values until the next accepted request.
REQ-022 START=1 in the DONE cycle SHALL be accepted, since the block is IDLE then; back-to-back conversions therefore have no dead cycle.
REQ-023 Changes on BCD_IN after the accepting edge SHALL NOT affect the result.
REQ-024 For valid inputs, BIN_OUT SHALL equal the decimal value of BCD_IN for every value 0 .. 10^NDIG-1.

Reset
REQ-025 RST=1 SHALL force state IDLE, BUSY=0, DONE=0, ERR=0, BIN_OUT=0, and clear the counter and internal registers on the next rising edge.
REQ-026 RST SHALL take priority over START and over any in-flight conversion; an aborted conversion produces no DONE.
REQ-027 START sampled with RST=1 SHALL be discarded.

Verification
REQ-028 BCD_IN=0x999, START pulse -> DONE exactly 11 cycles later, BIN_OUT=999 (0x3E7), ERR=0.
REQ-029 BCD_IN=0x000 -> BIN_OUT=0, ERR=0; BCD_IN=0x405 -> BIN_OUT=405 (0x195), ERR=0.
REQ-030 BCD_IN=0x1A3 with previous BIN_OUT=0x195 -> next cycle DONE=1, ERR=1, BIN_OUT stays 0x195, BUSY never high.
REQ-031 START held high through a 0x123 conversion with BCD_IN changed mid-conversion -> single result BIN_OUT=123; a second conversion starts on the DONE cycle and yields its own DONE 11 cycles later.
REQ-032 RST asserted on the 5th SHIFT cycle -> next edge all outputs 0, no DONE; a new START afterwards converts 0x250 -> 250.
REQ-033 Exhaustive sweep 000..999 with NDIG=3, BW=10 -> BIN_OUT matches the reference integer on each DONE.

Source files
------------

// File: rtl/sub3_bcd2bin.sv
// sub3_bcd2bin: packed BCD to binary converter using reverse double-dabble.
//
// Each conversion shifts the {digit register, binary shift register} pair
// right by one bit per cycle. After each shift, every BCD digit whose value
// is 8 or more is reduced by 3. This undoes the add-3 correction of a
// binary-to-BCD converter. After BW shifts, the shift register holds the
// binary value.
//
// Parameters
//   NDIG    number of packed BCD input digits
//   BW      binary output width; 2**BW must be >= 10**NDIG
//
// Ports
//   CLK     rising-edge clock
//   RST     synchronous, active-high reset
//   START   conversion request; accepted only while idle
//   BCD_IN  packed BCD operand (digit 0 in bits [3:0]); sampled on the accepting edge
//   BUSY    high while a conversion is in progress
//   DONE    one-cycle pulse when a conversion finishes or a request is rejected
//   BIN_OUT registered binary result; holds until the next accepted request
//   ERR     set when the last accepted request contained a digit above 9
module sub3_bcd2bin #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [4*NDIG-1:0] BCD_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic [BW-1:0]     BIN_OUT,
  output logic              ERR
);

  // Counter must be able to hold the value BW.
  localparam int CW = $clog2(BW + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state;
  logic [4*NDIG-1:0] digits;
  logic [BW-1:0]     sr;
  logic [CW-1:0]     cnt;

  logic [4*NDIG-1:0] digits_nxt;
  logic [BW-1:0]     sr_nxt;
  logic              last_iter;

  // True when any packed digit lies outside 0..9.
  function automatic logic has_bad_digit(input logic [4*NDIG-1:0] v);
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Inverse of the add-3 cell. A digit that reaches 8 or more after the right
  // shift received a carried-in bit worth 5 in decimal rather than 8.
  function automatic logic [3:0] sub3(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  always_comb begin
    {digits_nxt, sr_nxt} = {digits, sr} >> 1;
    for (int i = 0; i < NDIG; i++) begin
      digits_nxt[4*i +: 4] = sub3(digits_nxt[4*i +: 4]);
    end
  end

  // The edge that performs iteration BW sees the counter at BW-1.
  assign last_iter = (cnt == CW'(BW - 1));

  assign BUSY = (state == SHIFT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      digits  <= '0;
      sr      <= '0;
      cnt     <= '0;
      BIN_OUT <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (has_bad_digit(BCD_IN)) begin
              // Rejected request: report the error at once, keep the old result.
              ERR  <= 1'b1;
              DONE <= 1'b1;
            end else begin
              digits <= BCD_IN;
              sr     <= '0;
              cnt    <= '0;
              ERR    <= 1'b0;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          digits <= digits_nxt;
          sr     <= sr_nxt;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            BIN_OUT <= sr_nxt;
            DONE    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub3_bcd2bin.sv
// Testbench for sub3_bcd2bin (NDIG=3, BW=10). It applies a table of directed
// vectors, then hand-written sequences for held START, mid-conversion reset
// and a full 000..999 sweep.
module tb_sub3_bcd2bin;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [11:0] BCD_IN;
  logic        BUSY;
  logic        DONE;
  logic [9:0]  BIN_OUT;
  logic        ERR;

  int ntests = 0;
  int nfail  = 0;

  sub3_bcd2bin #(.NDIG(3), .BW(10)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .BCD_IN (BCD_IN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .BIN_OUT(BIN_OUT),
    .ERR    (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count edges after the accepting edge until DONE is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One request: pulse START, scramble BCD_IN after acceptance, check result.
  task automatic run_vec(input logic [11:0] bcd, input logic [9:0] eb,
                         input logic ee, input string nm);
    int n;
    BCD_IN = bcd;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    BCD_IN = ~bcd;
    if (ee) begin
      check({nm, " rej DONE"}, 32'(DONE), 32'd1);
      check({nm, " rej ERR"}, 32'(ERR), 32'd1);
      check({nm, " rej BUSY"}, 32'(BUSY), 32'd0);
      check({nm, " rej BIN_OUT"}, 32'(BIN_OUT), 32'(eb));
    end else begin
      check({nm, " BUSY"}, 32'(BUSY), 32'd1);
      wait_done(n);
      check({nm, " latency"}, 32'(n), 32'd10);
      check({nm, " BIN_OUT"}, 32'(BIN_OUT), 32'(eb));
      check({nm, " ERR"}, 32'(ERR), 32'd0);
      check({nm, " BUSY end"}, 32'(BUSY), 32'd0);
    end
    tick();
    check({nm, " DONE pulse"}, 32'(DONE), 32'd0);
    check({nm, " hold BIN_OUT"}, 32'(BIN_OUT), 32'(eb));
    check({nm, " hold ERR"}, 32'(ERR), 32'(ee));
    check({nm, " BUSY after"}, 32'(BUSY), 32'(0));
  endtask

  initial begin
    int n;
    logic [11:0] b;
    bit seen;

    vecs[0] = '{12'h999, 10'd999, 1'b0};
    vecs[1] = '{12'h000, 10'd0,   1'b0};
    vecs[2] = '{12'h405, 10'd405, 1'b0};
    vecs[3] = '{12'h1A3, 10'd405, 1'b1};
    vecs[4] = '{12'h090, 10'd90,  1'b0};
    vecs[5] = '{12'h00F, 10'd90,  1'b1};
    vecs[6] = '{12'h001, 10'd1,   1'b0};
    vecs[7] = '{12'hA00, 10'd1,   1'b1};
    vecs[8] = '{12'h512, 10'd512, 1'b0};
    vecs[9] = '{12'h789, 10'd789, 1'b0};

    RST = 1'b1; START = 1'b1; BCD_IN = 12'h999;
    repeat (3) tick();
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset DONE", 32'(DONE), 32'd0);
    check("reset ERR", 32'(ERR), 32'd0);
    check("reset BIN_OUT", 32'(BIN_OUT), 32'd0);
    START = 1'b0;
    RST   = 1'b0;
    tick();
    check("post-reset BUSY", 32'(BUSY), 32'd0);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, $sformatf("vec%0d", i));

    // START held high: mid-conversion changes ignored, then back-to-back accept.
    BCD_IN = 12'h123;
    START  = 1'b1;
    tick();
    check("held BUSY", 32'(BUSY), 32'd1);
    tick(); tick();
    BCD_IN = 12'h777;
    n = 2;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
    check("held latency", 32'(n), 32'd10);
    check("held BIN_OUT", 32'(BIN_OUT), 32'd123);
    tick();
    START = 1'b0;
    check("b2b DONE low", 32'(DONE), 32'd0);
    check("b2b BUSY", 32'(BUSY), 32'd1);
    wait_done(n);
    check("b2b latency", 32'(n), 32'd10);
    check("b2b BIN_OUT", 32'(BIN_OUT), 32'd777);
    tick();

    // Reset on the 5th SHIFT cycle aborts the conversion with no DONE.
    BCD_IN = 12'h999;
    START  = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    RST   = 1'b1;
    START = 1'b1;
    tick();
    check("abort BUSY", 32'(BUSY), 32'd0);
    check("abort DONE", 32'(DONE), 32'd0);
    check("abort ERR", 32'(ERR), 32'd0);
    check("abort BIN_OUT", 32'(BIN_OUT), 32'd0);
    RST   = 1'b0;
    START = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DONE || BUSY) seen = 1'b1;
    end
    check("abort quiet", 32'(seen), 32'd0);
    run_vec(12'h250, 10'd250, 1'b0, "after abort");

    // Exhaustive sweep against the decimal value.
    for (int i = 0; i < 1000; i++) begin
      b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      run_vec(b, 10'(i), 1'b0, $sformatf("sweep%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
